fifo_serializer: RTL and testbench
==================================

Name: fifo_serializer

Overview:
- Sits directly downstream of the lab FIFO. It drains one width_p-bit word per dequeue and emits the word as width_p/chunk_p narrow chunks over a valid/ready interface, least-significant chunk first.
- Feeds narrow sinks such as a byte-ish link or a per-field consumer.
- Wraps the FIFO's combinational read port, so the FIFO itself needs no extra output register.

Parameters:
- width_p, 27: width of the FIFO word; must equal the FIFO's width_p.
- chunk_p, 9: width of each output chunk; width_p must be an exact multiple of chunk_p, otherwise elaboration fails.
- count_width_p, 16: width of the completed-word counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clear_i  in  1  synchronous active-high reset.
- fifo_d_i  in  width_p  FIFO head word (the FIFO's d_o).
- fifo_valid_i  in  1  FIFO non-empty (the FIFO's valid_o).
- fifo_deque_o  out  1  dequeue strobe to the FIFO's deque_i; combinational.
- data_o  out  chunk_p  current chunk.
- valid_o  out  1  data_o holds a valid chunk.
- ready_i  in  1  sink accepts a chunk; a transfer occurs when valid_o & ready_i.
- last_o  out  1  the current chunk is the final chunk of its word; only meaningful while valid_o=1.
- busy_o  out  1  the serializer holds an unfinished word (state SEND).
- words_o  out  count_width_p  number of fully transferred words; wraps modulo 2^count_width_p.

Behaviour:
- Derived values: n_lp = width_p/chunk_p; the chunk counter cnt_r is max(1, $clog2(n_lp)) bits.
- Reset:
  - clear_i is synchronous and active-high. At the edge where clear_i=1: state=IDLE, cnt_r=0, shift register=0, words_o=0.
  - Hence valid_o=0, last_o=0, busy_o=0, data_o=0 in the following cycle.
  - fifo_deque_o is forced 0 in any cycle where clear_i=1.
- State IDLE:
  - valid_o=0.
  - If fifo_valid_i=1: fifo_deque_o=1 in the same cycle. At the edge, shreg<=fifo_d_i, cnt_r<=0, state<=SEND.
  - If fifo_valid_i=0: stay in IDLE, fifo_deque_o=0.
- State SEND:
  - valid_o=1, data_o=shreg[chunk_p-1:0], last_o=(cnt_r==n_lp-1), busy_o=1.
  - On a transfer with last_o=0: shreg shifts right by chunk_p with zero fill, and cnt_r increments.
  - On a transfer with last_o=1: words_o increments.
    - If fifo_valid_i=1, fifo_deque_o=1 in the same cycle; the next word loads with cnt_r<=0 and the state stays SEND. There is no bubble between words.
    - Otherwise state<=IDLE.
  - With ready_i=0: all state holds; data_o, last_o and valid_o stay stable (no retraction).
- Latency: a word present at the FIFO head in cycle t while IDLE drives valid_o=1 with chunk 0 in cycle t+1. Steady-state throughput is one chunk per cycle with ready_i held high.
- fifo_deque_o = ~clear_i & fifo_valid_i & (IDLE | (SEND & valid_o & ready_i & last_o)). It never asserts while the FIFO is empty.
- n_lp=1 (chunk_p=width_p): every chunk is last; the block acts as a one-entry pass-through register.
- Clear mid-word: the partial word is discarded and not counted. The FIFO is not dequeued during the clear cycle.
- fifo_d_i is sampled only in dequeue cycles; its value at other times is ignored.
- words_o increments by exactly 1 per completed word and wraps from all-ones to 0.

Test Plan:
- Single word: after clear, FIFO presents 27'h00C0401 -> fifo_deque_o pulses one cycle. Next cycles give data_o = 9'h001, 9'h002, 9'h003 with last_o only on 9'h003. Then valid_o=0, words_o=1.
- Backpressure: same word, ready_i low for 3 cycles while 9'h002 is presented -> data_o holds 9'h002, valid_o stays 1, no dequeue. Transfer resumes when ready_i=1.
- Back-to-back: FIFO holds 27'h00C0401 then 27'h01BC09A, ready_i=1 -> 6 consecutive valid chunks 001,002,003,09A,1E0,006 with no gap. Second dequeue occurs in the cycle 003 transfers. words_o=2.
- Empty FIFO: fifo_valid_i=0 for 10 cycles -> valid_o=0, fifo_deque_o=0 throughout.
- Clear mid-word: clear_i high in the cycle 9'h002 is presented, with fifo_valid_i=1 -> no dequeue that cycle. Next cycle valid_o=0, busy_o=0, words_o=0. The following cycle dequeues and serializes the FIFO head fresh starting at chunk 0.
- Counter wrap: with count_width_p=2, serialize 5 words -> words_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fifo_serializer_if.sv
// Bundle of the FIFO read port and the narrow chunk stream around fifo_serializer.
// master = serializer side, slave = FIFO/sink side.
interface fifo_serializer_if #(
    parameter int width_p = 27,
    parameter int chunk_p = 9
);
    logic [width_p-1:0] fifo_d_i;
    logic               fifo_valid_i;
    logic               fifo_deque_o;
    logic [chunk_p-1:0] data_o;
    logic               valid_o;
    logic               ready_i;
    logic               last_o;

    modport master (
        input  fifo_d_i,
        input  fifo_valid_i,
        input  ready_i,
        output fifo_deque_o,
        output data_o,
        output valid_o,
        output last_o
    );

    modport slave (
        output fifo_d_i,
        output fifo_valid_i,
        output ready_i,
        input  fifo_deque_o,
        input  data_o,
        input  valid_o,
        input  last_o
    );
endinterface

// File: rtl/fifo_serializer.sv
// Drains one FIFO word per dequeue and emits it as LSB-first chunks; chunk 0 one cycle after the dequeue.
// Holds data_o/last_o/valid_o stable while ready_i is low; next word loads on the last transfer with no bubble.
module fifo_serializer #(
    parameter int width_p       = 27,
    parameter int chunk_p       = 9,
    parameter int count_width_p = 16
) (
    input  logic                     clk,
    input  logic                     clear_i,
    fifo_serializer_if.master        bus,
    output logic                     busy_o,
    output logic [count_width_p-1:0] words_o
);
    localparam int n_lp      = width_p / chunk_p;
    localparam int cnt_w_lp  = (n_lp > 1) ? $clog2(n_lp) : 1;

    if ((chunk_p < 1) || ((width_p % chunk_p) != 0)) begin : g_bad_params
        $error("fifo_serializer: width_p must be an exact multiple of chunk_p");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [cnt_w_lp-1:0]      cnt_q, cnt_d;
    logic [width_p-1:0]       shreg_q, shreg_d;
    logic [count_width_p-1:0] words_q, words_d;

    logic send;
    logic last;
    logic xfer;
    logic deque;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        words_d = words_q;

        send  = (state_q == SEND);
        last  = send && (cnt_q == cnt_w_lp'(n_lp - 1));
        xfer  = send && bus.ready_i;
        // Refill either from IDLE or on the final chunk so consecutive words abut.
        deque = !clear_i && bus.fifo_valid_i && (!send || (xfer && last));

        if (deque) begin
            shreg_d = bus.fifo_d_i;
            cnt_d   = '0;
            state_d = SEND;
        end else if (xfer && last) begin
            state_d = IDLE;
        end else if (xfer) begin
            shreg_d = shreg_q >> chunk_p;
            cnt_d   = cnt_q + cnt_w_lp'(1);
        end

        if (xfer && last) begin
            words_d = words_q + count_width_p'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            words_q <= words_d;
        end
    end

    assign bus.fifo_deque_o = deque;
    assign bus.valid_o      = send;
    assign bus.data_o       = shreg_q[chunk_p-1:0];
    assign bus.last_o       = last;
    assign busy_o           = send;
    assign words_o          = words_q;
endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed chunks, an independent monitor checks every transfer.
module tb_fifo_serializer;
    localparam int W  = 27;
    localparam int C  = 9;
    localparam int CW = 2;

    localparam logic [W-1:0] WORD_A = 27'h00C0401;
    localparam logic [W-1:0] WORD_B = 27'h01BC09A;

    logic          clk = 1'b0;
    logic          clear_i;
    logic          busy_o;
    logic [CW-1:0] words_o;

    always #5 clk = ~clk;

    fifo_serializer_if #(.width_p(W), .chunk_p(C)) bus ();

    fifo_serializer #(.width_p(W), .chunk_p(C), .count_width_p(CW)) dut (
        .clk     (clk),
        .clear_i (clear_i),
        .bus     (bus),
        .busy_o  (busy_o),
        .words_o (words_o)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  fifo_q[$];
    logic [C:0]    exp_q[$];
    logic [CW-1:0] exp_words;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void drive();
        bus.fifo_valid_i = (fifo_q.size() != 0);
        bus.fifo_d_i     = (fifo_q.size() != 0) ? fifo_q[0] : 27'h5A5A5A5;
    endfunction

    task automatic expect_word(input logic [C-1:0] c0, input logic [C-1:0] c1, input logic [C-1:0] c2);
        exp_q.push_back({1'b0, c0});
        exp_q.push_back({1'b0, c1});
        exp_q.push_back({1'b1, c2});
    endtask

    task automatic push_a();
        fifo_q.push_back(WORD_A);
        expect_word(9'h001, 9'h002, 9'h003);
        drive();
    endtask

    task automatic push_b();
        fifo_q.push_back(WORD_B);
        expect_word(9'h09A, 9'h1E0, 9'h006);
        drive();
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !bus.valid_o) done = 1'b1;
        end
        check({name, "_drain"}, {31'd0, done}, 32'd1);
    endtask

    // FIFO model: a dequeue seen before the edge removes the head just after it.
    initial begin
        logic do_pop;
        forever begin
            @(negedge clk);
            do_pop = bus.fifo_deque_o;
            @(posedge clk);
            #1;
            if (do_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
            drive();
        end
    end

    // Monitor: compares every accepted chunk and the word counter against the scoreboard.
    initial begin
        logic         stall;
        logic [C-1:0] held;
        logic [C:0]   e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (clear_i) begin
                check("deque_in_clear", {31'd0, bus.fifo_deque_o}, 32'd0);
                stall = 1'b0;
            end else begin
                check("words_o", {30'd0, words_o}, {30'd0, exp_words});
                if (bus.fifo_deque_o) check("deque_nonempty", {31'd0, bus.fifo_valid_i}, 32'd1);
                if (stall) begin
                    check("hold_valid", {31'd0, bus.valid_o}, 32'd1);
                    check("hold_data", {23'd0, bus.data_o}, {23'd0, held});
                end
                if (bus.valid_o && bus.ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_chunk", {23'd0, bus.data_o}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("chunk_data", {23'd0, bus.data_o}, {23'd0, e[C-1:0]});
                        check("chunk_last", {31'd0, bus.last_o}, {31'd0, e[C]});
                        if (e[C]) exp_words = exp_words + 1'b1;
                    end
                end
                stall = bus.valid_o && !bus.ready_i;
                held  = bus.data_o;
            end
        end
    end

    initial begin
        logic [C-1:0] b2b [6];
        bit           seen;
        b2b = '{9'h001, 9'h002, 9'h003, 9'h09A, 9'h1E0, 9'h006};

        clear_i     = 1'b1;
        bus.ready_i = 1'b1;
        exp_words   = '0;
        drive();

        // Reset with a word already waiting: no dequeue while clear is high.
        repeat (2) @(posedge clk);
        #2 push_a();
        @(negedge clk);
        check("clr_deque", {31'd0, bus.fifo_deque_o}, 32'd0);
        @(posedge clk);
        #1 clear_i = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        check("rst_last", {31'd0, bus.last_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_data", {23'd0, bus.data_o}, 32'd0);
        check("rst_words", {30'd0, words_o}, 32'd0);
        check("single_deque", {31'd0, bus.fifo_deque_o}, 32'd1);
        @(negedge clk);
        check("single_lat_valid", {31'd0, bus.valid_o}, 32'd1);
        check("single_lat_data", {23'd0, bus.data_o}, 32'h001);
        check("single_deque_once", {31'd0, bus.fifo_deque_o}, 32'd0);
        wait_drain("single");
        check("single_words", {30'd0, words_o}, 32'd1);

        // Backpressure on chunk 002 with the next word already waiting.
        @(posedge clk);
        #2 push_a();
        @(posedge clk);
        @(posedge clk);
        #1 bus.ready_i = 1'b0;
        #1 push_b();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_data", {23'd0, bus.data_o}, 32'h002);
            check("bp_valid", {31'd0, bus.valid_o}, 32'd1);
            check("bp_no_deque", {31'd0, bus.fifo_deque_o}, 32'd0);
        end
        @(posedge clk);
        #1 bus.ready_i = 1'b1;
        wait_drain("bp");
        check("bp_words", {30'd0, words_o}, 32'd3);

        // Back-to-back words: six chunks with no gap, refill on chunk 003.
        @(posedge clk);
        #2 push_a();
        push_b();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        check("b2b_start", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("b2b_valid", {31'd0, bus.valid_o}, 32'd1);
            check("b2b_data", {23'd0, bus.data_o}, {23'd0, b2b[i]});
            if (i == 2) check("b2b_deque", {31'd0, bus.fifo_deque_o}, 32'd1);
            @(negedge clk);
        end
        check("b2b_end_valid", {31'd0, bus.valid_o}, 32'd0);
        check("b2b_words", {30'd0, words_o}, 32'd1);

        // Empty FIFO stays quiet.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("empty_valid", {31'd0, bus.valid_o}, 32'd0);
            check("empty_deque", {31'd0, bus.fifo_deque_o}, 32'd0);
        end

        // Clear while chunk 002 is shown; B is then taken fresh from chunk 0.
        @(posedge clk);
        #2 push_a();
        push_b();
        @(posedge clk);
        @(posedge clk);
        #1 clear_i = 1'b1;
        exp_q.delete();
        exp_words = '0;
        expect_word(9'h09A, 9'h1E0, 9'h006);
        @(negedge clk);
        check("midclr_data", {23'd0, bus.data_o}, 32'h002);
        @(posedge clk);
        #1 clear_i = 1'b0;
        @(negedge clk);
        check("midclr_valid", {31'd0, bus.valid_o}, 32'd0);
        check("midclr_busy", {31'd0, busy_o}, 32'd0);
        check("midclr_words", {30'd0, words_o}, 32'd0);
        check("midclr_deque", {31'd0, bus.fifo_deque_o}, 32'd1);
        @(negedge clk);
        check("midclr_fresh", {23'd0, bus.data_o}, 32'h09A);
        wait_drain("midclr");
        check("midclr_words_end", {30'd0, words_o}, 32'd1);

        // Counter wrap: five words give 1,2,3,0,1.
        @(posedge clk);
        #1 clear_i = 1'b1;
        exp_words = '0;
        @(posedge clk);
        #1 clear_i = 1'b0;
        #1 push_a();
        push_b();
        push_a();
        push_b();
        push_a();
        wait_drain("wrap");
        check("wrap_words", {30'd0, words_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
